// File: rtl/match_scorer.sv
// Match scorer: counts game wins from the game FSM state code, decides set and
// match winners, and freezes the score once the match has been decided.
module match_scorer #(
  parameter int GAMES_PER_SET = 6,
  parameter int SETS_TO_WIN   = 2
) (
  input  logic       clk,
  input  logic       rs_n,
  input  logic       clr,
  input  logic [2:0] y,
  output logic [3:0] games1,
  output logic [3:0] games2,
  output logic [2:0] sets1,
  output logic [2:0] sets2,
  output logic       set_done,
  output logic [1:0] set_winner,
  output logic       match_done,
  output logic [1:0] match_winner
);

  localparam logic [0:0] ST_PLAY       = 1'b0;
  localparam logic [0:0] ST_MATCH_OVER = 1'b1;
  localparam logic [2:0] Y_GAME1 = 3'b011;
  localparam logic [2:0] Y_GAME2 = 3'b100;
  localparam logic [3:0] GPS     = 4'(GAMES_PER_SET);
  localparam logic [3:0] GPS_P1  = 4'(GAMES_PER_SET + 1);
  localparam logic [2:0] STW     = 3'(SETS_TO_WIN);

  logic [0:0] state_q, state_d;
  logic [2:0] y_prev_q, y_prev_d;
  logic [3:0] games1_q, games1_d, games2_q, games2_d;
  logic [2:0] sets1_q, sets1_d, sets2_q, sets2_d;
  logic       set_done_q, set_done_d;
  logic [1:0] set_winner_q, set_winner_d;
  logic       match_done_q, match_done_d;
  logic [1:0] match_winner_q, match_winner_d;

  logic       win1, win2, set_win;
  logic [3:0] g_inc, g_opp;
  logic [2:0] s_inc;
  logic [1:0] who;

  // A game code counts only on the cycle it first appears.
  assign win1 = (y == Y_GAME1) && (y_prev_q != Y_GAME1);
  assign win2 = (y == Y_GAME2) && (y_prev_q != Y_GAME2);

  assign g_inc = (win1 ? games1_q : games2_q) + 4'd1;
  assign g_opp = win1 ? games2_q : games1_q;
  assign s_inc = (win1 ? sets1_q : sets2_q) + 3'd1;
  assign who   = win1 ? 2'b01 : 2'b10;

  // Lead subtraction is only meaningful once the scorer is ahead.
  assign set_win = (g_inc > g_opp) &&
                   (((g_inc >= GPS) && ((g_inc - g_opp) >= 4'd2)) || (g_inc == GPS_P1));

  always_comb begin
    state_d        = state_q;
    y_prev_d       = y;
    games1_d       = games1_q;
    games2_d       = games2_q;
    sets1_d        = sets1_q;
    sets2_d        = sets2_q;
    set_done_d     = 1'b0;
    set_winner_d   = set_winner_q;
    match_done_d   = match_done_q;
    match_winner_d = match_winner_q;
    if (clr) begin
      state_d        = ST_PLAY;
      y_prev_d       = 3'b000;
      games1_d       = 4'd0;
      games2_d       = 4'd0;
      sets1_d        = 3'd0;
      sets2_d        = 3'd0;
      set_winner_d   = 2'b00;
      match_done_d   = 1'b0;
      match_winner_d = 2'b00;
    end else if ((state_q == ST_PLAY) && (win1 || win2)) begin
      if (set_win) begin
        games1_d     = 4'd0;
        games2_d     = 4'd0;
        set_done_d   = 1'b1;
        set_winner_d = who;
        if (win1) sets1_d = s_inc;
        else      sets2_d = s_inc;
        if (s_inc == STW) begin
          match_done_d   = 1'b1;
          match_winner_d = who;
          state_d        = ST_MATCH_OVER;
        end
      end else if (win1) begin
        games1_d = g_inc;
      end else begin
        games2_d = g_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state_q        <= ST_PLAY;
      y_prev_q       <= 3'b000;
      games1_q       <= 4'd0;
      games2_q       <= 4'd0;
      sets1_q        <= 3'd0;
      sets2_q        <= 3'd0;
      set_done_q     <= 1'b0;
      set_winner_q   <= 2'b00;
      match_done_q   <= 1'b0;
      match_winner_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      y_prev_q       <= y_prev_d;
      games1_q       <= games1_d;
      games2_q       <= games2_d;
      sets1_q        <= sets1_d;
      sets2_q        <= sets2_d;
      set_done_q     <= set_done_d;
      set_winner_q   <= set_winner_d;
      match_done_q   <= match_done_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign games1       = games1_q;
  assign games2       = games2_q;
  assign sets1        = sets1_q;
  assign sets2        = sets2_q;
  assign set_done     = set_done_q;
  assign set_winner   = set_winner_q;
  assign match_done   = match_done_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_match_scorer.sv
// Bench for match_scorer: directed scenarios plus random y/clr traffic, all
// checked against a score-keeping model of tennis set/match rules.
module tb_match_scorer;

  localparam int G = 6;
  localparam int S = 2;

  logic       clk;
  logic       rs_n;
  logic       clr;
  logic [2:0] y;
  logic [3:0] games1, games2;
  logic [2:0] sets1, sets2;
  logic       set_done;
  logic [1:0] set_winner;
  logic       match_done;
  logic [1:0] match_winner;

  int n_checks;
  int n_fail;

  // Reference model: per-player score arrays (index 0 = P1, 1 = P2).
  int m_g[2];
  int m_s[2];
  int m_prev;
  int m_sd, m_sw, m_md, m_mw;

  match_scorer #(.GAMES_PER_SET(G), .SETS_TO_WIN(S)) dut (
    .clk(clk), .rs_n(rs_n), .clr(clr), .y(y),
    .games1(games1), .games2(games2), .sets1(sets1), .sets2(sets2),
    .set_done(set_done), .set_winner(set_winner),
    .match_done(match_done), .match_winner(match_winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_g[0] = 0; m_g[1] = 0; m_s[0] = 0; m_s[1] = 0;
    m_prev = 0; m_sd = 0; m_sw = 0; m_md = 0; m_mw = 0;
  endtask

  task automatic model_step(input int yv, input bit c);
    int w, me, opp;
    if (c) begin
      model_reset();
      return;
    end
    w = -1;
    if (yv == 3 && m_prev != 3) w = 0;
    if (yv == 4 && m_prev != 4) w = 1;
    m_prev = yv;
    m_sd = 0;
    if (m_md == 0 && w >= 0) begin
      me  = m_g[w] + 1;
      opp = m_g[1-w];
      if ((me >= G && me - opp >= 2) || me == G + 1) begin
        m_g[0] = 0;
        m_g[1] = 0;
        m_s[w]++;
        m_sd = 1;
        m_sw = w + 1;
        if (m_s[w] == S) begin
          m_md = 1;
          m_mw = w + 1;
        end
      end else begin
        m_g[w] = me;
      end
    end
  endtask

  task automatic check_all();
    chk("games1", 32'(games1), m_g[0]);
    chk("games2", 32'(games2), m_g[1]);
    chk("sets1", 32'(sets1), m_s[0]);
    chk("sets2", 32'(sets2), m_s[1]);
    chk("set_done", 32'(set_done), m_sd);
    chk("set_winner", 32'(set_winner), m_sw);
    chk("match_done", 32'(match_done), m_md);
    chk("match_winner", 32'(match_winner), m_mw);
  endtask

  // Drive between edges, clock once, then compare just after the edge.
  task automatic step(input logic [2:0] yv, input bit c);
    y   = yv;
    clr = c;
    @(posedge clk);
    model_step(int'(yv), c);
    #1;
    check_all();
  endtask

  task automatic game(input int p);
    step((p == 1) ? 3'b011 : 3'b100, 1'b0);
    step(3'b000, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rs_n = 1'b0;
    clr  = 1'b0;
    y    = 3'b000;
    model_reset();
    #3;
    check_all();
    #4 rs_n = 1'b1;

    // Six straight P1 games take the first set.
    for (int i = 0; i < 6; i++) game(1);
    chk("first_set_sets1", 32'(sets1), 1);

    // 5-5, then P1, P2, P2 decides 7-6 for P2, then one more P2 game.
    for (int i = 0; i < 5; i++) begin
      game(1);
      game(2);
    end
    game(1);
    chk("tb_6_5", {games1, games2}, {4'd6, 4'd5});
    game(2);
    chk("tb_6_6", {games1, games2}, {4'd6, 4'd6});
    step(3'b100, 1'b0);
    chk("tb_win_done", 32'(set_done), 1);
    chk("tb_win_who", 32'(set_winner), 2);
    step(3'b000, 1'b0);
    game(2);

    // Held game code counts once.
    for (int i = 0; i < 4; i++) step(3'b011, 1'b0);
    step(3'b000, 1'b0);
    chk("held_g1", 32'(games1), 1);

    // Clean start, two 6-0 sets to P2, then events are ignored.
    step(3'b000, 1'b1);
    for (int i = 0; i < 12; i++) game(2);
    chk("match_winner_p2", 32'(match_winner), 2);
    for (int i = 0; i < 16; i++) step(3'($urandom_range(0, 7)), 1'b0);

    // clr together with a game code at 3-2 discards the event.
    step(3'b000, 1'b1);
    game(1); game(1); game(1); game(2); game(2);
    step(3'b011, 1'b1);
    chk("clr_games1", 32'(games1), 0);
    step(3'b000, 1'b0);

    // Async reset mid-cycle at 4-4, sets 1-0.
    for (int i = 0; i < 6; i++) game(1);
    for (int i = 0; i < 4; i++) begin
      game(1);
      game(2);
    end
    chk("pre_rst_4_4", {games1, games2, sets1}, {4'd4, 4'd4, 3'd1});
    #2 rs_n = 1'b0;
    model_reset();
    #1 check_all();
    #2 rs_n = 1'b1;
    for (int i = 0; i < 3; i++) game(2);

    // Random traffic with holds, unused codes and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] yv;
      bit c;
      case ($urandom_range(0, 3))
        0: yv = 3'b000;
        1: yv = 3'b011;
        2: yv = 3'b100;
        default: yv = 3'($urandom_range(1, 7));
      endcase
      c = ($urandom_range(0, 99) == 0) || (m_md != 0 && $urandom_range(0, 9) == 0);
      step(yv, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
